// File: rtl/uart_tx_fifo.sv
// ============================================================================
// uart_tx_fifo : byte FIFO feeding an 8N1 serial transmitter, LSB first.
// UART_PARITY_EN adds an even-parity bit.              Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        bussy,
  output logic                        tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] C_LVL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [LW-1:0]   r_level;
  logic            r_bussy;
  logic            r_tx;
  logic [7:0]      r_mem [FIFO_DEPTH];

  logic            w_push;
  logic            w_pop;
  logic            w_bit_done;

  // Full is taken from the pre-pop level, so a write on a pop edge is still dropped.
  assign full       = (r_level == C_LVL_FULL);
  assign level      = r_level;
  assign bussy      = r_bussy;
  assign tx         = r_tx;
  assign w_push     = wr_en && !full;
  assign w_pop      = (r_state == S_IDLE) && (r_level != '0);
  assign w_bit_done = (r_cnt == C_CNT_MAX);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_bussy <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_bussy <= (r_state != S_IDLE) || (r_level != '0);

      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase

      // tx follows the state one cycle later, keeping the line glitch-free.
      case (r_state)
        S_IDLE: begin
          r_tx  <= 1'b1;
          r_cnt <= '0;
          r_idx <= '0;
          if (w_pop) begin
            r_shift <= r_mem[r_rptr];
            r_state <= S_START;
          end
        end
        S_START: begin
          r_tx <= 1'b0;
          if (w_bit_done) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          r_tx <= r_shift[r_idx];
          if (w_bit_done) begin
            r_cnt <= '0;
            if (r_idx == 3'd7) begin
`ifdef UART_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          r_tx <= ^r_shift;
          if (w_bit_done) begin
            r_cnt   <= '0;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`endif
        S_STOP: begin
          r_tx <= 1'b1;
          if (w_bit_done) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// tb_uart_tx_fifo : random and directed stimulus against a line-timeline model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

  localparam int CPB     = 4;
  localparam int DEPTH   = 4;
  localparam int DEF_CPB = 5208;
`ifdef UART_PARITY_EN
  localparam int NBITS   = 11;
`else
  localparam int NBITS   = 10;
`endif
  localparam int FRAME   = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, bussy, tx;
  logic [2:0] level;

  logic       d_wr_en = 1'b0;
  logic [7:0] d_wr_data = 8'h00;
  logic       d_full, d_bussy, d_tx;
  logic [2:0] d_level;

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .level(level), .bussy(bussy), .tx(tx)
  );

  uart_tx_fifo dut_def (
    .clk(clk), .rst(rst), .wr_en(d_wr_en), .wr_data(d_wr_data),
    .full(d_full), .level(d_level), .bussy(d_bussy), .tx(d_tx)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a queue of pending bytes plus the edge at which the current
  // frame was popped; the line value is read off that frame's bit timeline.
  logic [7:0]  q[$];
  longint      cyc   = 0;
  longint      pop_t = -1000000;
  logic [10:0] fr    = '1;
  logic        m_tx    = 1'b1;
  logic        m_bussy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin : mdl
    longint     t;
    bit         in_frame;
    int         sz;
    logic [7:0] b;
    if (rst) begin
      q.delete();
      pop_t   = -1000000;
      m_tx    = 1'b1;
      m_bussy = 1'b0;
    end else begin
      t        = cyc + 1;
      sz       = q.size();
      in_frame = (t - 1 >= pop_t) && (t - 1 < pop_t + FRAME);
      m_bussy  = (sz != 0) || in_frame;
      if (!in_frame && sz != 0) begin
        b      = q.pop_front();
        fr     = '1;
        fr[0]  = 1'b0;
        fr[8:1] = b;
`ifdef UART_PARITY_EN
        fr[9]  = ^b;
`endif
        pop_t  = t;
      end
      if (wr_en && sz < DEPTH) q.push_back(wr_data);
      m_tx = (t >= pop_t + 1 && t <= pop_t + FRAME) ? fr[int'((t - pop_t - 1) / CPB)] : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("tx",    tx,    m_tx);
      chk("bussy", bussy, m_bussy);
      chk("level", level, q.size());
      chk("full",  full,  q.size() == DEPTH);
    end
  end

  initial begin
    int n, m;
    logic [7:0] singles [3];
    singles[0] = 8'h78;
    singles[1] = 8'h07;
    singles[2] = 8'h03;

    repeat (3) @(negedge clk);
    chk("rst_tx",    tx,    1);
    chk("rst_bussy", bussy, 0);
    chk("rst_level", level, 0);
    chk("rst_full",  full,  0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Single characters into an idle FIFO: latency and busy window.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = singles[k];
      @(negedge clk); wr_en = 1'b0;
      n = 0;
      while (tx !== 1'b0 && n < 10) begin @(negedge clk); n++; end
      chk("start_latency", n, 2);
      while (bussy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
      chk("bussy_fall", n, FRAME + 2);
      repeat (5) @(negedge clk);
    end

    // Burst of five, a dropped sixth, then hold the line full across pops.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = 8'(8'h41 + i);
    end
    @(negedge clk);
    chk("burst_level", level, 4);
    chk("burst_full",  full,  1);
    wr_data = 8'h46;
    @(negedge clk);
    chk("drop_level", level, 4);
    for (int i = 0; i < 130; i++) begin
      wr_data = 8'($urandom);
      @(negedge clk);
    end
    wr_en = 1'b0;
    repeat (5 * FRAME + 20) @(negedge clk);
    chk("drain1", bussy, 0);

    // Random traffic: a dense stretch then a sparse one.
    for (int i = 0; i < 800; i++) begin
      wr_en   = ($urandom_range(0, (i < 200) ? 1 : 30) == 0);
      wr_data = 8'($urandom);
      @(negedge clk);
    end
    wr_en = 1'b0;
    repeat (5 * FRAME + 20) @(negedge clk);
    chk("drain2", bussy, 0);

    // Asynchronous reset in the middle of 0x55 with two bytes queued.
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h55;
    @(negedge clk); wr_data = 8'h11;
    @(negedge clk); wr_data = 8'h22;
    @(negedge clk); wr_en = 1'b0;
    chk("pre_rst_level", level, 2);
    repeat (9) @(negedge clk);
    chk("pre_rst_tx", tx, 0);
    #1 rst = 1'b1;
    #1;
    chk("async_tx",    tx,    1);
    chk("async_bussy", bussy, 0);
    chk("async_level", level, 0);
    chk("async_full",  full,  0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) n++;
    end
    chk("no_frame_after_rst", n, 0);
    chk("post_rst_bussy", bussy, 0);

    // Default-rate instance: 0x0A has LSB 0, so the first low run is start + bit 0.
    @(negedge clk); d_wr_en = 1'b1; d_wr_data = 8'h0A;
    @(negedge clk); d_wr_en = 1'b0;
    n = 0;
    while (d_tx !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    chk("def_latency", n, 2);
    m = 0;
    while (d_tx === 1'b0 && m < 3 * DEF_CPB) begin @(negedge clk); n++; m++; end
    chk("def_low_run", m, 2 * DEF_CPB);
    while (d_bussy !== 1'b0 && n < 60000) begin @(negedge clk); n++; end
    chk("def_bussy_fall", n, NBITS * DEF_CPB + 2);
    chk("def_tx_idle", d_tx, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
